// File: rtl/diagv2_syscall_unit.sv
// ECALL handler: stalls the core, streams PRINT strings from data memory over a
// ready/valid character port, and latches the EXIT code then halts.
module diagv2_syscall_unit #(
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned MAX_STR_LEN = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ecall,
   input  logic [DATA_W-1:0] a7,
   input  logic [DATA_W-1:0] a0,
   output logic              stall,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              tx_valid,
   output logic [7:0]        tx_data,
   input  logic              tx_ready,
   output logic              exited,
   output logic [DATA_W-1:0] exit_code,
   output logic              bad_call
);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, ACK, HALTED} state_t;

   localparam int unsigned CNT_W = $clog2(MAX_STR_LEN + 1);
   // Truncation fires when the post-increment count reaches MAX_STR_LEN-1.
   localparam logic [CNT_W-1:0] TRUNC_AT = CNT_W'(MAX_STR_LEN - 1);

   state_t            state;
   logic [ADDR_W-1:0] line;
   logic [2:0]        offset;
   logic [2:0]        offset_inc;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_inc;
   logic [DATA_W-1:0] buffer;
   logic [7:0]        wait_byte;
   logic [7:0]        next_byte;

   assign mem_addr = line;

   always_comb begin
      offset_inc = offset + 3'd1;
      count_inc  = count + 1'b1;
      wait_byte  = mem_rdata[{offset, 3'b000} +: 8];
      next_byte  = buffer[{offset_inc, 3'b000} +: 8];
   end

   // Combinational so the core cannot advance on the ECALL cycle itself.
   always_comb begin
      stall = 1'b0;
      if (!reset)
         stall = (ecall && state == IDLE) ||
                 (state inside {FETCH, WAIT, EMIT, HALTED});
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         line      <= '0;
         offset    <= '0;
         count     <= '0;
         buffer    <= '0;
         mem_req   <= 1'b0;
         tx_valid  <= 1'b0;
         tx_data   <= '0;
         exited    <= 1'b0;
         exit_code <= '0;
         bad_call  <= 1'b0;
      end else begin
         mem_req  <= 1'b0;
         bad_call <= 1'b0;
         case (state)
            IDLE: begin
               if (ecall) begin
                  if (a7 == DATA_W'(93)) begin
                     exit_code <= a0;
                     exited    <= 1'b1;
                     state     <= HALTED;
                  end else if (a7 == DATA_W'(4)) begin
                     line    <= a0[ADDR_W+2:3];
                     offset  <= a0[2:0];
                     count   <= '0;
                     mem_req <= 1'b1;
                     state   <= FETCH;
                  end else begin
                     bad_call <= 1'b1;
                     state    <= ACK;
                  end
               end
            end
            FETCH: state <= WAIT;
            WAIT: begin
               buffer   <= mem_rdata;
               tx_data  <= wait_byte;
               tx_valid <= (wait_byte != 8'h00);
               state    <= EMIT;
            end
            EMIT: begin
               // tx_valid low here means the current byte is the terminator.
               if (!tx_valid) begin
                  state <= ACK;
               end else if (tx_ready) begin
                  count <= count_inc;
                  if (count_inc == TRUNC_AT) begin
                     tx_valid <= 1'b0;
                     state    <= ACK;
                  end else if (offset == 3'd7) begin
                     offset   <= '0;
                     line     <= line + 1'b1;
                     tx_valid <= 1'b0;
                     mem_req  <= 1'b1;
                     state    <= FETCH;
                  end else begin
                     offset   <= offset_inc;
                     tx_data  <= next_byte;
                     tx_valid <= (next_byte != 8'h00);
                  end
               end
            end
            ACK:     state <= IDLE;
            HALTED:  state <= HALTED;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
